// File: rtl/connect4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : connect4_pkg
//  Description : Shared constants for the Connect-4 game datapath: board
//                geometry, default player count and the turn sequencer
//                state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package connect4_pkg;

    // Board geometry; a full board holds one piece per cell.
    localparam int BOARD_ROWS      = 6;
    localparam int BOARD_COLS      = 7;
    localparam int MAX_MOVES       = BOARD_ROWS * BOARD_COLS;

    // Classic two-player game unless the integrator asks for more.
    localparam int DEFAULT_PLAYERS = 2;

    // Turn sequencer states: PLAY accepts moves, DONE is locked until reset.
    typedef logic [0:0] seq_state_t;
    localparam seq_state_t c_ST_PLAY = 1'b0;
    localparam seq_state_t c_ST_DONE = 1'b1;

endpackage : connect4_pkg
`default_nettype wire

// File: rtl/turn_timeout_timer.sv
`default_nettype none
// ============================================================================
//  Module      : turn_timeout_timer
//  Description : Per-turn cycle counter. Counts while 'run' is high, returns
//                to zero on 'clear', and flags the last allowed cycle of a
//                turn on 'tc'. With TIMEOUT_CYCLES == 0 the counter is not
//                built and 'tc' is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module turn_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TMR_W          = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tc
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            // Terminal value: the turn is forfeited on the edge that sees it.
            localparam logic [TMR_W-1:0] c_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

            logic [TMR_W-1:0] r_count;

            // Cycle counter: clear wins over run; the owner clears it on tc.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (run) begin
                    r_count <= r_count + TMR_W'(1);
                end
            end

            assign tc = (r_count == c_LAST);
        end else begin : g_no_timer
            // Timeout disabled: keep the ports connected but inert.
            logic w_unused;
            assign w_unused = ^{clk, reset, run, clear};
            assign tc       = 1'b0;
        end
    endgenerate

endmodule : turn_timeout_timer
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : turn_sequencer
//  Description : Rotates a one-hot current-player token among NUM_PLAYERS on
//                each committed move. Supports undo, move counting with
//                board-full detection, win lock with winner capture and an
//                optional per-turn timeout that forfeits the turn.
//                All outputs are registered (one-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module turn_sequencer
    import connect4_pkg::*;
#(
    parameter int NUM_PLAYERS    = DEFAULT_PLAYERS,
    parameter int MAX_MOVES      = connect4_pkg::MAX_MOVES,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              undo,
    input  logic                              win,
    output logic [NUM_PLAYERS-1:0]            turn,
    output logic [$clog2(MAX_MOVES+1)-1:0]    move_count,
    output logic                              board_full,
    output logic                              game_over,
    output logic [NUM_PLAYERS-1:0]            winner,
    output logic                              timeout_pulse
);

    localparam int CNT_W = $clog2(MAX_MOVES + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]       c_MAX_CNT  = CNT_W'(MAX_MOVES);
    localparam logic [CNT_W-1:0]       c_LAST_CNT = CNT_W'(MAX_MOVES - 1);
    localparam logic [NUM_PLAYERS-1:0] c_PLAYER0  = NUM_PLAYERS'(1);

    // ------------------------------------------------------------------
    // State and datapath registers with their next-value wires
    // ------------------------------------------------------------------
    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic [NUM_PLAYERS-1:0] r_turn;
    logic [NUM_PLAYERS-1:0] w_turn_nxt;
    logic [NUM_PLAYERS-1:0] r_winner;
    logic [NUM_PLAYERS-1:0] w_winner_nxt;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_nxt;
    logic                   r_full;
    logic                   w_full_nxt;
    logic                   r_over;
    logic                   w_over_nxt;
    logic                   r_pulse;
    logic                   w_pulse_nxt;

    // ------------------------------------------------------------------
    // Event decode (priority win > enable > undo > timeout)
    // ------------------------------------------------------------------
    logic                   w_play;
    logic                   w_win;
    logic                   w_move;
    logic                   w_back;
    logic                   w_tmo;
    logic                   w_tc;
    logic                   w_tmr_clear;
    logic [NUM_PLAYERS-1:0] w_rotl;
    logic [NUM_PLAYERS-1:0] w_rotr;

    assign w_play = (r_state == c_ST_PLAY);
    assign w_win  = w_play && win;
    // A committed move only counts while the board still has room.
    assign w_move = w_play && !win && enable && (r_count < c_MAX_CNT);
    // Undo is dropped whenever enable is present, and ignored on an empty board.
    assign w_back = w_play && !win && !enable && undo && (r_count != '0);
    // An ignored undo does not shield the turn from timing out.
    assign w_tmo  = w_play && !win && !enable && !w_back && w_tc;

    assign w_tmr_clear = w_move || w_back || w_tmo;

    // Left rotation hands the token to the next player; right goes back one.
    assign w_rotl = {r_turn[NUM_PLAYERS-2:0], r_turn[NUM_PLAYERS-1]};
    assign w_rotr = {r_turn[0], r_turn[NUM_PLAYERS-1:1]};

    // ------------------------------------------------------------------
    // Per-turn timeout counter; runs only while the game is live
    // ------------------------------------------------------------------
    turn_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .run   (w_play),
        .clear (w_tmr_clear),
        .tc    (w_tc)
    );

    // State register: PLAY out of reset, DONE locks until the next reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_PLAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a win or the move that fills the board ends the game.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_PLAY: begin
                if (w_win) begin
                    w_state_nxt = c_ST_DONE;
                end else if (w_move && (r_count == c_LAST_CNT)) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_DONE;
            end
            default: begin
                w_state_nxt = c_ST_PLAY;
            end
        endcase
    end

    // Output next values: hold by default, update on the single winning event.
    always_comb begin
        w_turn_nxt   = r_turn;
        w_count_nxt  = r_count;
        w_full_nxt   = r_full;
        w_over_nxt   = r_over;
        w_winner_nxt = r_winner;
        w_pulse_nxt  = 1'b0;

        if (w_win) begin
            w_winner_nxt = r_turn;
            w_over_nxt   = 1'b1;
        end

        if (w_move) begin
            w_turn_nxt  = w_rotl;
            w_count_nxt = r_count + CNT_W'(1);
            if (r_count == c_LAST_CNT) begin
                w_full_nxt = 1'b1;
                w_over_nxt = 1'b1;
            end
        end

        if (w_back) begin
            w_turn_nxt  = w_rotr;
            w_count_nxt = r_count - CNT_W'(1);
        end

        if (w_tmo) begin
            w_turn_nxt  = w_rotl;
            w_pulse_nxt = 1'b1;
        end

        // A corrupted token is repaired by handing the turn to player 0.
        if (!$onehot(r_turn)) begin
            w_turn_nxt = c_PLAYER0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_turn   <= c_PLAYER0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_over   <= 1'b0;
            r_winner <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_turn   <= w_turn_nxt;
            r_count  <= w_count_nxt;
            r_full   <= w_full_nxt;
            r_over   <= w_over_nxt;
            r_winner <= w_winner_nxt;
            r_pulse  <= w_pulse_nxt;
        end
    end

    assign turn          = r_turn;
    assign move_count    = r_count;
    assign board_full    = r_full;
    assign game_over     = r_over;
    assign winner        = r_winner;
    assign timeout_pulse = r_pulse;

endmodule : turn_sequencer
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turn_sequencer
//  Description : Self-checking bench. Four sequencer configurations share one
//                stimulus stream; each is compared every cycle against a
//                player-index reference model, plus directed scenario checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_sequencer;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;
    logic undo   = 1'b0;
    logic win    = 1'b0;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // DUT configurations: A(2,42,0) B(3,42,0) C(2,42,5) D(5,7,3)
    // ------------------------------------------------------------------
    logic [1:0] turn_a, win_a;  logic [5:0] cnt_a;  logic full_a, over_a, pulse_a;
    logic [2:0] turn_b, win_b;  logic [5:0] cnt_b;  logic full_b, over_b, pulse_b;
    logic [1:0] turn_c, win_c;  logic [5:0] cnt_c;  logic full_c, over_c, pulse_c;
    logic [4:0] turn_d, win_d;  logic [2:0] cnt_d;  logic full_d, over_d, pulse_d;

    turn_sequencer #(.NUM_PLAYERS(2), .MAX_MOVES(42), .TIMEOUT_CYCLES(0)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .undo(undo), .win(win),
        .turn(turn_a), .move_count(cnt_a), .board_full(full_a), .game_over(over_a),
        .winner(win_a), .timeout_pulse(pulse_a));
    turn_sequencer #(.NUM_PLAYERS(3), .MAX_MOVES(42), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .undo(undo), .win(win),
        .turn(turn_b), .move_count(cnt_b), .board_full(full_b), .game_over(over_b),
        .winner(win_b), .timeout_pulse(pulse_b));
    turn_sequencer #(.NUM_PLAYERS(2), .MAX_MOVES(42), .TIMEOUT_CYCLES(5)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .undo(undo), .win(win),
        .turn(turn_c), .move_count(cnt_c), .board_full(full_c), .game_over(over_c),
        .winner(win_c), .timeout_pulse(pulse_c));
    turn_sequencer #(.NUM_PLAYERS(5), .MAX_MOVES(7), .TIMEOUT_CYCLES(3)) u_d (
        .clk(clk), .reset(reset), .enable(enable), .undo(undo), .win(win),
        .turn(turn_d), .move_count(cnt_d), .board_full(full_d), .game_over(over_d),
        .winner(win_d), .timeout_pulse(pulse_d));

    // ------------------------------------------------------------------
    // Reference model: player index, move total, turn clock, game flags
    // ------------------------------------------------------------------
    typedef struct {
        int p;
        int cnt;
        int wnr;
        int tmr;
        bit full;
        bit over;
        bit pulse;
    } mdl_t;

    mdl_t  m[4];
    int    np_tab[4] = '{2, 3, 2, 5};
    int    mx_tab[4] = '{42, 42, 42, 7};
    int    to_tab[4] = '{0, 0, 5, 3};
    string nm[4]     = '{"A", "B", "C", "D"};

    function automatic mdl_t mdl_step(mdl_t s, bit rst_n, bit en, bit un, bit wn,
                                      int np, int mx, int tmo);
        mdl_t n = s;
        n.pulse = 1'b0;
        if (!rst_n) begin
            n.p = 0; n.cnt = 0; n.wnr = -1; n.tmr = 0; n.full = 0; n.over = 0;
            return n;
        end
        if (s.over) return n;
        if (wn) begin
            n.wnr  = s.p;
            n.over = 1'b1;
        end else if (en) begin
            if (s.cnt < mx) begin
                n.p   = (s.p + 1) % np;
                n.cnt = s.cnt + 1;
                n.tmr = 0;
                if (n.cnt == mx) begin
                    n.full = 1'b1;
                    n.over = 1'b1;
                end
            end
        end else if (un && s.cnt > 0) begin
            n.p   = (s.p + np - 1) % np;
            n.cnt = s.cnt - 1;
            n.tmr = 0;
        end else if (tmo > 0) begin
            if (s.tmr == tmo - 1) begin
                n.p     = (s.p + 1) % np;
                n.pulse = 1'b1;
                n.tmr   = 0;
            end else begin
                n.tmr = s.tmr + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            m[k] = mdl_step(m[k], reset, enable, undo, win, np_tab[k], mx_tab[k], to_tab[k]);
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_one(int k, logic [31:0] t, logic [31:0] c, logic [31:0] w,
                           logic f, logic o, logic p);
        mdl_t e = m[k];
        check($sformatf("%s.turn", nm[k]), t, 32'(1) << e.p);
        check($sformatf("%s.move_count", nm[k]), c, 32'(e.cnt));
        check($sformatf("%s.board_full", nm[k]), {31'd0, f}, {31'd0, e.full});
        check($sformatf("%s.game_over", nm[k]), {31'd0, o}, {31'd0, e.over});
        check($sformatf("%s.winner", nm[k]), w, (e.wnr < 0) ? 32'd0 : (32'(1) << e.wnr));
        check($sformatf("%s.timeout_pulse", nm[k]), {31'd0, p}, {31'd0, e.pulse});
    endtask

    task automatic compare_all();
        cmp_one(0, 32'(turn_a), 32'(cnt_a), 32'(win_a), full_a, over_a, pulse_a);
        cmp_one(1, 32'(turn_b), 32'(cnt_b), 32'(win_b), full_b, over_b, pulse_b);
        cmp_one(2, 32'(turn_c), 32'(cnt_c), 32'(win_c), full_c, over_c, pulse_c);
        cmp_one(3, 32'(turn_d), 32'(cnt_d), 32'(win_d), full_d, over_d, pulse_d);
    endtask

    // One clock: inputs were set away from the edge, outputs sampled 1 after it.
    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(bit e, bit u, bit w);
        enable = e; undo = u; win = w;
        tick();
        enable = 1'b0; undo = 1'b0; win = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; undo = 1'b0; win = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [1:0] exp2 [3];
        logic [2:0] exp3 [6];
        exp2 = '{2'b10, 2'b01, 2'b10};
        exp3 = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b001, 3'b100};

        // Reset state
        do_reset();
        check("rst.turn", 32'(turn_a), 32'd1);
        check("rst.count", 32'(cnt_a), 32'd0);
        check("rst.over", 32'(over_a), 32'd0);
        check("rst.winner", 32'(win_a), 32'd0);

        // Three enables, two players
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            check("rot2.turn", 32'(turn_a), 32'(exp2[i]));
        end
        check("rot2.count", 32'(cnt_a), 32'd3);
        check("rot2.over", 32'(over_a), 32'd0);

        // Three players: four moves then two undos
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, i >= 4, 0);
            check("rot3.turn", 32'(turn_b), 32'(exp3[i]));
        end
        check("rot3.count", 32'(cnt_b), 32'd2);

        // Undo on an empty board, then enable+undo together
        do_reset();
        drive(0, 1, 0);
        check("undo0.turn", 32'(turn_a), 32'd1);
        check("undo0.count", 32'(cnt_a), 32'd0);
        drive(1, 1, 0);
        check("enundo.turn", 32'(turn_a), 32'd2);
        check("enundo.count", 32'(cnt_a), 32'd1);

        // Fill the board
        do_reset();
        for (int i = 0; i < 42; i++) begin
            drive(1, 0, 0);
            if (i == 40) check("fill41.full", 32'(full_a), 32'd0);
        end
        check("fill.full", 32'(full_a), 32'd1);
        check("fill.over", 32'(over_a), 32'd1);
        check("fill.count", 32'(cnt_a), 32'd42);
        drive(1, 0, 0);
        check("fill43.count", 32'(cnt_a), 32'd42);
        check("fill43.turn", 32'(turn_a), 32'd1);

        // Win beats enable and locks the game
        do_reset();
        drive(1, 0, 0);
        drive(1, 0, 1);
        check("win.winner", 32'(win_a), 32'd2);
        check("win.over", 32'(over_a), 32'd1);
        check("win.turn", 32'(turn_a), 32'd2);
        check("win.count", 32'(cnt_a), 32'd1);
        drive(1, 0, 0);
        drive(0, 1, 0);
        check("lock.count", 32'(cnt_a), 32'd1);
        check("lock.turn", 32'(turn_a), 32'd2);
        do_reset();
        check("rel.winner", 32'(win_a), 32'd0);
        check("rel.over", 32'(over_a), 32'd0);
        check("rel.turn", 32'(turn_a), 32'd1);

        // Timeout: idle forfeits on the 5th edge after release
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0);
            check("tmo.idle_pulse", 32'(pulse_c), 32'd0);
        end
        drive(0, 0, 0);
        check("tmo.pulse", 32'(pulse_c), 32'd1);
        check("tmo.turn", 32'(turn_c), 32'd2);
        check("tmo.count", 32'(cnt_c), 32'd0);
        drive(0, 0, 0);
        check("tmo.pulse_end", 32'(pulse_c), 32'd0);

        // Enable on the 4th edge restarts the turn clock
        do_reset();
        for (int i = 0; i < 3; i++) drive(0, 0, 0);
        drive(1, 0, 0);
        check("tmo_rst.pulse", 32'(pulse_c), 32'd0);
        check("tmo_rst.turn", 32'(turn_c), 32'd2);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0);
            check("tmo_rst.idle_pulse", 32'(pulse_c), 32'd0);
        end
        drive(0, 0, 0);
        check("tmo_rst.late_pulse", 32'(pulse_c), 32'd1);
        check("tmo_rst.late_turn", 32'(turn_c), 32'd1);

        // Randomized play against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 99) != 0);
            enable = ($urandom_range(0, 99) < 30);
            undo   = ($urandom_range(0, 99) < 25);
            win    = ($urandom_range(0, 99) < 2);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_turn_sequencer
`default_nettype wire
